// File: rtl/freq_sweeper_multi.sv
// Multi-profile DDS frequency sweeper: accepts a sweep command over valid/ready and
// steps the tuning word through up/down/triangle/hold profiles with dwell, repeat and abort.
module freq_sweeper_multi #(
  parameter int FREQ_W  = 32,
  parameter int DWELL_W = 16,
  parameter int STEPS_W = 16,
  parameter int REP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FREQ_W-1:0]  cmd_init_freq,
  input  logic [FREQ_W-1:0]  cmd_step,
  input  logic [STEPS_W-1:0] cmd_num_steps,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic [1:0]         cmd_mode,
  input  logic [REP_W-1:0]   cmd_repeat,
  input  logic               abort,
  output logic [FREQ_W-1:0]  dds_freq,
  output logic               freq_update,
  output logic               sweep_start,
  output logic               sweep_done,
  output logic               sweep_aborted,
  output logic               sweep_active,
  output logic [STEPS_W-1:0] step_index
);

  typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, HOLD = 2'd2} state_e;

  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic               upd_q, upd_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               active_q, active_d;
  logic [STEPS_W-1:0] idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic               falling_q, falling_d;
  logic [FREQ_W-1:0]  init_q, init_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [STEPS_W-1:0] nsteps_q, nsteps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic [REP_W-1:0]   rep_q, rep_d;

  logic accept_s;
  logic last_dwell_s;
  logic pass_end_s;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    freq_d    = freq_q;
    upd_d     = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    active_d  = active_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    falling_d = falling_q;
    init_d    = init_q;
    step_d    = step_q;
    nsteps_d  = nsteps_q;
    dwell_d   = dwell_q;
    mode_d    = mode_q;
    rep_d     = rep_q;
    pass_end_s   = 1'b0;
    accept_s     = ready_q & cmd_valid & ~abort;
    // A zero dwell behaves as a one-cycle dwell
    last_dwell_s = (dwell_q == '0) || (cnt_q == dwell_q - DWELL_W'(1));

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept_s) begin
          init_d    = cmd_init_freq;
          step_d    = cmd_step;
          nsteps_d  = cmd_num_steps;
          dwell_d   = cmd_dwell;
          mode_d    = cmd_mode;
          rep_d     = cmd_repeat;
          freq_d    = cmd_init_freq;
          upd_d     = 1'b1;
          start_d   = 1'b1;
          active_d  = 1'b1;
          idx_d     = '0;
          cnt_d     = '0;
          pass_d    = '0;
          falling_d = 1'b0;
          ready_d   = 1'b0;
          state_d   = (cmd_mode == MODE_HOLD) ? HOLD : DWELL;
        end else begin
          state_d = IDLE;
        end
      end
      DWELL, HOLD: begin
        if (abort) begin
          done_d    = 1'b1;
          aborted_d = 1'b1;
          active_d  = 1'b0;
          ready_d   = 1'b0;
          state_d   = IDLE;
        end else if (state_q == HOLD) begin
          state_d = HOLD;
        end else if (last_dwell_s) begin
          cnt_d = '0;
          if (mode_q == MODE_TRI && falling_q) begin
            if (idx_q == '0) begin
              pass_end_s = 1'b1;
            end else begin
              idx_d  = idx_q - STEPS_W'(1);
              freq_d = freq_q - step_q;
              upd_d  = 1'b1;
            end
          end else if (idx_q != nsteps_q) begin
            idx_d  = idx_q + STEPS_W'(1);
            freq_d = (mode_q == MODE_DOWN) ? freq_q - step_q : freq_q + step_q;
            upd_d  = 1'b1;
          end else if (mode_q == MODE_TRI && nsteps_q != '0) begin
            // Peak reached: turn around without repeating the peak point
            falling_d = 1'b1;
            idx_d     = idx_q - STEPS_W'(1);
            freq_d    = freq_q - step_q;
            upd_d     = 1'b1;
          end else begin
            pass_end_s = 1'b1;
          end
          if (pass_end_s) begin
            if (pass_q == rep_q) begin
              done_d   = 1'b1;
              active_d = 1'b0;
              ready_d  = 1'b0;
              state_d  = IDLE;
            end else begin
              pass_d    = pass_q + REP_W'(1);
              freq_d    = init_q;
              idx_d     = '0;
              falling_d = 1'b0;
              upd_d     = 1'b1;
            end
          end else begin
            pass_d = pass_q;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; ready_q resets high so cmd_ready rises as soon as reset drops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      freq_q    <= '0;
      upd_q     <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      active_q  <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      pass_q    <= '0;
      falling_q <= 1'b0;
      init_q    <= '0;
      step_q    <= '0;
      nsteps_q  <= '0;
      dwell_q   <= '0;
      mode_q    <= 2'd0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      freq_q    <= freq_d;
      upd_q     <= upd_d;
      start_q   <= start_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      active_q  <= active_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      falling_q <= falling_d;
      init_q    <= init_d;
      step_q    <= step_d;
      nsteps_q  <= nsteps_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
      rep_q     <= rep_d;
    end
  end

  assign cmd_ready     = ready_q & ~abort & ~reset;
  assign dds_freq      = freq_q;
  assign freq_update   = upd_q;
  assign sweep_start   = start_q;
  assign sweep_done    = done_q;
  assign sweep_aborted = aborted_q;
  assign sweep_active  = active_q;
  assign step_index    = idx_q;

endmodule

// File: doc/freq_sweeper_multi.md
Name: freq_sweeper_multi

Overview:
Parametrised successor to the single-mode frequency sweeper. It accepts a complete sweep command through a valid/ready handshake. It then drives the DDS tuning word through up, down, triangle or hold profiles, with a programmable point count, dwell time and repeat count. It sits between the UART command FIFO/frame parser and dds_sine_generator, and it adds abort and progress reporting.

Parameters:
FREQ_W, 32, width of tuning word, initial frequency and step
DWELL_W, 16, width of the per-point dwell cycle count
STEPS_W, 16, width of the step count and step_index
REP_W, 8, width of the repeat count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_init_freq  in  FREQ_W  starting tuning word
cmd_step  in  FREQ_W  unsigned frequency increment per point
cmd_num_steps  in  STEPS_W  number of steps per leg (N)
cmd_dwell  in  DWELL_W  clock cycles each point is held (0 treated as 1)
cmd_mode  in  2  0=up, 1=down, 2=triangle, 3=hold
cmd_repeat  in  REP_W  extra passes (R); total passes = R+1
abort  in  1  terminate the active sweep
dds_freq  out  FREQ_W  tuning word to the DDS
freq_update  out  1  1-cycle pulse whenever dds_freq is loaded
sweep_start  out  1  1-cycle pulse on the first point of a command
sweep_done  out  1  1-cycle pulse when a command ends, whether completed or aborted
sweep_aborted  out  1  valid with sweep_done; 1 when the command ended by abort
sweep_active  out  1  high from the first point until done
step_index  out  STEPS_W  current point index within the leg

Behaviour:
- Reset: every output is 0 (dds_freq=0, cmd_ready=0 during reset); the FSM enters IDLE. Reset overrides all other activity, including mid-sweep. cmd_ready=1 on the first cycle after reset is released.
- States: IDLE, DWELL, HOLD.
- IDLE: cmd_ready=1 only when abort=0. A command is accepted when cmd_valid&&cmd_ready; all cmd_* fields are registered.
- Cycle after acceptance:
  - dds_freq=init_freq, freq_update=1, sweep_start=1, sweep_active=1, step_index=0.
  - Next state is HOLD if mode=3, otherwise DWELL.
- DWELL: each point holds for max(dwell,1) cycles. On the last cycle of a dwell the next point loads, so the new dds_freq is visible the following cycle together with a freq_update pulse.
- Arithmetic: up computes dds_freq+step; down computes dds_freq-step; both are modulo 2^FREQ_W and wrap silently. There is no saturation.
- Up/down profile: points k=0..N, giving N+1 points; step_index=k.
- Triangle profile:
  - Rise over k=0..N using +step, then fall using -step with step_index counting N-1..0.
  - The peak is not repeated, giving 2N+1 points per pass.
- N=0: a single point at init_freq per pass.
- End of pass, i.e. after the last point's dwell:
  - Passes remaining: reload dds_freq=init_freq, step_index=0, pulse freq_update. Do not pulse sweep_start.
  - No passes remaining: pulse sweep_done with sweep_aborted=0, clear sweep_active and return to IDLE.
  - dds_freq keeps its last value after completion.
- HOLD (mode 3): dds_freq=init_freq indefinitely; repeat, step and num_steps are ignored. The sweep exits only on abort.
- Abort:
  - Sampled in DWELL or HOLD.
  - Next cycle: sweep_done=1, sweep_aborted=1, sweep_active=0, state IDLE. dds_freq holds its value; no freq_update.
  - Abort takes precedence over a point load or end of pass in the same cycle.
  - Abort in IDLE is ignored except that it blocks cmd_ready that cycle.
- Throughput: cmd_ready re-asserts the cycle after sweep_done, so a new command can be accepted on that cycle and a back-to-back command starts one cycle later.
- Cycle count: a non-aborted sweep lasts (points × max(dwell,1)) × (R+1) cycles from sweep_start to the cycle before sweep_done.
- Pulse rule: sweep_aborted is 0 whenever sweep_done=0.

Test Plan:
- Up: init=0x100, step=0x10, N=3, dwell=4, R=0 -> dds_freq 0x100,0x110,0x120,0x130, each held 4 cycles; 4 freq_update pulses; sweep_done 16 cycles after sweep_start, aborted=0.
- Down with wrap: init=0x8, step=0x10, N=1, dwell=2 -> 0x8 then 0xFFFFFFF8; step_index 0,1; done after 4 cycles.
- Triangle: init=0x100, step=0x10, N=2, dwell=0 (treated as 1) -> 0x100,0x110,0x120,0x110,0x100 on consecutive cycles; step_index 0,1,2,1,0.
- Repeat: up, N=1, dwell=1, R=2 -> sequence 0x100,0x110 three times; a single sweep_start; freq_update 6 times; done after 6 cycles.
- Abort: hold mode init=0x55 -> dds_freq=0x55 for 100 cycles; abort -> next cycle sweep_done=1, aborted=1, cmd_ready=1 the following cycle, dds_freq stays 0x55. Repeat the abort during an up sweep on a point-load cycle: no load occurs.
- Reset mid-sweep and handshake: assert reset during DWELL -> all outputs 0. Hold cmd_valid during a sweep -> not accepted until IDLE. Assert cmd_valid and abort together in IDLE -> command not accepted.
